// File: rtl/placar_pkg.sv
// Shared types and constants for the score/lives board: FSM states, 7-segment glyphs
// (active-low, bit6=g .. bit0=a) and a saturating-free 4-digit BCD adder.
package placar_pkg;

  typedef enum logic [1:0] {
    StJogando,
    StInvuln,
    StPerdeu
  } estado_e;

  localparam int unsigned VidasIniciaisDef = 3;
  localparam int unsigned InvulnCiclosDef  = 25_000_000;
  localparam int unsigned PontosDef        = 1;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegP     = 7'b0001100;
  localparam logic [6:0] SegL     = 7'b1000111;
  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;

  // Returns {carry_out, sum}; a set carry_out means the true sum exceeded 9999.
  function automatic logic [16:0] bcd_soma(input logic [15:0] s, input logic [3:0] inc);
    logic [4:0]  t;
    logic [3:0]  c;
    logic [15:0] r;
    c = inc;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      t = {1'b0, s[4*i +: 4]} + {1'b0, c};
      if (t > 5'd9) begin
        t = t - 5'd10;
        r[4*i +: 4] = t[3:0];
        c = 4'd1;
      end else begin
        r[4*i +: 4] = t[3:0];
        c = 4'd0;
      end
    end
    return {c[0], r};
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// BCD digit to active-low 7-segment pattern; codes above 9 show blank.
module seg7_dec
  import placar_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegBlank;
    case (bcd_i)
      4'd0:    seg_o = Seg0;
      4'd1:    seg_o = Seg1;
      4'd2:    seg_o = Seg2;
      4'd3:    seg_o = Seg3;
      4'd4:    seg_o = Seg4;
      4'd5:    seg_o = Seg5;
      4'd6:    seg_o = Seg6;
      4'd7:    seg_o = Seg7;
      4'd8:    seg_o = Seg8;
      4'd9:    seg_o = Seg9;
      default: seg_o = SegBlank;
    endcase
  end

endmodule

// File: rtl/placar_hex.sv
// Game scoreboard: counts enemy kills in BCD, tracks lives with a post-hit invulnerability
// window, and drives six 7-segment displays.
module placar_hex
  import placar_pkg::*;
#(
  parameter int unsigned VIDAS_INICIAIS     = VidasIniciaisDef,
  parameter int unsigned INVULN_CICLOS      = InvulnCiclosDef,
  parameter int unsigned PONTOS_POR_INIMIGO = PontosDef
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pausa,
  input  logic       acerto_inimigo,
  input  logic       nave_atingida,
  output logic       perdeu,
  output logic [3:0] vidas,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam int unsigned CntW = (INVULN_CICLOS > 1) ? $clog2(INVULN_CICLOS) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(INVULN_CICLOS - 1);

  estado_e       estado_q, estado_d;
  logic [3:0]    vidas_q, vidas_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]   score_q, score_d;
  logic          acerto_q, nave_q;
  logic          ev_acerto, ev_nave;
  logic [16:0]   soma;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      estado_q <= StJogando;
      vidas_q  <= 4'(VIDAS_INICIAIS);
      cnt_q    <= '0;
      score_q  <= '0;
    end else begin
      estado_q <= estado_d;
      vidas_q  <= vidas_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
    end
    // Histories track the inputs even in reset, so a level held across release is no event.
    acerto_q <= acerto_inimigo;
    nave_q   <= nave_atingida;
  end

  always_comb begin
    estado_d  = estado_q;
    vidas_d   = vidas_q;
    cnt_d     = cnt_q;
    score_d   = score_q;
    ev_acerto = acerto_inimigo & ~acerto_q & ~pausa;
    ev_nave   = nave_atingida & ~nave_q & ~pausa;
    soma      = bcd_soma(score_q, 4'(PONTOS_POR_INIMIGO));

    unique case (estado_q)
      StJogando: begin
        if (ev_nave) begin
          if (vidas_q > 4'd1) begin
            vidas_d  = vidas_q - 4'd1;
            cnt_d    = CntLoad;
            estado_d = StInvuln;
          end else begin
            vidas_d  = 4'd0;
            estado_d = StPerdeu;
          end
        end
      end
      StInvuln: begin
        if (!pausa) begin
          if (cnt_q == '0) begin
            estado_d = StJogando;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StPerdeu: begin
      end
      default: estado_d = StJogando;
    endcase

    // Kills still score on the same edge that costs the last life.
    if (ev_acerto && (estado_q != StPerdeu)) begin
      score_d = soma[16] ? 16'h9999 : soma[15:0];
    end
  end

  assign perdeu = (estado_q == StPerdeu);
  assign vidas  = vidas_q;

  always_comb begin
    HEX4 = SegBlank;
    if (estado_q == StPerdeu) begin
      HEX4 = SegL;
    end else if (pausa) begin
      HEX4 = SegP;
    end else if (estado_q == StInvuln) begin
      HEX4 = SegDash;
    end
  end

  seg7_dec u_hex0 (.bcd_i(score_q[3:0]),   .seg_o(HEX0));
  seg7_dec u_hex1 (.bcd_i(score_q[7:4]),   .seg_o(HEX1));
  seg7_dec u_hex2 (.bcd_i(score_q[11:8]),  .seg_o(HEX2));
  seg7_dec u_hex3 (.bcd_i(score_q[15:12]), .seg_o(HEX3));
  seg7_dec u_hex5 (.bcd_i(vidas_q),        .seg_o(HEX5));

endmodule
